mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data multiplexer among four requesters.
- Drives the mux select pair (s1, s0) and a one-hot grant vector.
- The selected requester's data appears on a single output bus.
- Sits between four producers and one shared consumer; replaces hand-driven select lines with a sequenced, starvation-free controller.

Parameters:
- DATA_W, 8: width of each requester's data word and of dout.
- HOLD_MAX, 4: maximum consecutive cycles one requester keeps the grant while others wait; range 1..15.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request per requester; req[k] held high while requester k wants the mux.
- din  input  4*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W].
- gnt  output 4  one-hot grant (registered); all-zero when idle.
- s1   output 1  mux select MSB (registered).
- s0   output 1  mux select LSB (registered); {s1,s0} = index of granted requester.
- dout output DATA_W  mux output, din slice selected by {s1,s0}, gated to 0 when gnt==0.
- valid output 1  high exactly when gnt != 0.

Behaviour:
- Interface fixed: one clock clk; rst synchronous, active-high, sampled on rising clk only.
- Reset values: gnt=4'b0000, s1=0, s0=0, valid=0, dout=0, state=IDLE, hold counter=0, last-grant pointer=3 (so requester 0 has top priority first).
- States:
  - IDLE: no grant.
  - GRANT: owner = index in {s1,s0}.
- Priority order: starts at (last+1) mod 4 and wraps upward. Example: last=1 gives order 2,3,0,1. The pointer updates to the winner on every new grant.
- IDLE -> GRANT: if req != 0 at edge N, the winner's gnt bit, s1/s0 and valid are set after edge N (1-cycle latency); counter=1.
- IDLE with req==0: remain IDLE, outputs unchanged (zero).
- GRANT, owner's req low at edge:
  - If any other req is high, the next winner is granted at that same edge (back-to-back, no idle cycle).
  - Otherwise go to IDLE: gnt=0, valid=0, s1/s0 hold their last value.
- GRANT, owner's req high, counter < HOLD_MAX: keep grant; counter+1.
- GRANT, owner's req high, counter == HOLD_MAX:
  - If another req is high, rotate to the next winner (excluding the owner); counter=1.
  - If no other request is pending, keep the grant and saturate the counter at HOLD_MAX.
- Counter is 4 bits and never wraps.
- Any new grant (including a rotation) resets the counter to 1.
- dout is combinational from registered s1/s0 and din: y = (~s1&~s0&i0)|(~s1&s0&i1)|(s1&~s0&i2)|(s1&s0&i3), applied bitwise across DATA_W and ANDed with valid.
- Simultaneous requests resolve purely by the rotating priority; no fixed priority exists after reset.
- A requester raising req while already owner has no effect.
- A requester dropping then re-raising req in consecutive cycles is treated as a new request; it is ranked lowest if it was the last winner.
- rst asserted mid-GRANT: at that edge all outputs return to reset values and the pointer returns to 3, regardless of req. Pending requests are re-arbitrated starting on the first edge with rst low.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[k]=1 implies {s1,s0}=k.
  - valid == |gnt.
  - No requester with req continuously high waits more than 3*HOLD_MAX cycles.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 -> gnt=0, s1=s0=0, valid=0, dout=0 throughout; first grant after release goes to requester 0.
- Single requester: req=4'b0100, din slice2=8'hA5 -> one cycle later gnt=4'b0100, {s1,s0}=2'b10, valid=1, dout=8'hA5; holds indefinitely with counter saturated at 4.
- Full contention: req=4'b1111 held, HOLD_MAX=4 -> grant sequence 0,1,2,3,0, each owner exactly 4 cycles, no gap cycles, dout tracks each slice.
- Early release: requesters 1 and 3 high; owner 1 drops req after 2 cycles -> gnt moves to 4'b1000 at that same edge; when 3 drops with no others pending -> IDLE, valid=0, dout=0.
- Rotation fairness: after requester 2 wins, req=4'b0101 -> next grant is requester 0 (order 3,0,1,2), not 2.
- Reset mid-grant: rst pulsed 1 cycle while gnt=4'b0010, req=4'b1010 -> outputs zero that cycle; the next grant goes to requester 1 (pointer reset to 3).

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 data multiplexer among four
//   requesters. The select pair and one-hot grant are registered; the data
//   path is a combinational AND-OR mux gated by valid.
//
// Ports
//   clk   : system clock, all state updates on the rising edge
//   rst   : synchronous reset, active-high
//   req   : per-requester request, held high while the mux is wanted
//   din   : packed data, requester k at [k*DATA_W +: DATA_W]
//   gnt   : registered one-hot grant, zero when idle
//   s1/s0 : registered mux select, {s1,s0} = index of granted requester
//   dout  : selected din slice, forced to zero when nothing is granted
//   valid : high exactly when gnt != 0
module mux4_rr_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   din,
    output logic [3:0]            gnt,
    output logic                  s1,
    output logic                  s0,
    output logic [DATA_W-1:0]     dout,
    output logic                  valid
);

    localparam logic [3:0] HoldMax = 4'(HOLD_MAX);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;

    logic [3:0]  others;
    logic [1:0]  win_all, win_oth, win;
    logic        do_grant;

    // First set bit of m scanning upward from last+1; last itself ranks lowest.
    function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] res;
        res = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (m[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        do_grant = 1'b0;
        win      = 2'd0;

        others  = req & ~(4'b0001 << sel_q);
        win_all = pick(req, last_q);
        win_oth = pick(others, last_q);

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    do_grant = 1'b1;
                    win      = win_all;
                end
            end
            StGrant: begin
                if (!req[sel_q]) begin
                    if (|others) begin
                        // Back-to-back handover, no idle cycle.
                        do_grant = 1'b1;
                        win      = win_oth;
                    end else begin
                        // Select lines keep their last value while idle.
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        cnt_d   = 4'd0;
                    end
                end else if (cnt_q < HoldMax) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (|others) begin
                    do_grant = 1'b1;
                    win      = win_oth;
                end else begin
                    // Nobody else waiting: keep the grant, counter saturates.
                    cnt_d = HoldMax;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                cnt_d   = 4'd0;
            end
        endcase

        if (do_grant) begin
            state_d = StGrant;
            gnt_d   = 4'b0001 << win;
            sel_d   = win;
            cnt_d   = 4'd1;
            last_d  = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            cnt_q   <= 4'd0;
            last_q  <= 2'd3;  // requester 0 ranks first after reset
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign valid = |gnt_q;

    assign dout = (({DATA_W{~s1 & ~s0}} & din[0*DATA_W +: DATA_W]) |
                   ({DATA_W{~s1 &  s0}} & din[1*DATA_W +: DATA_W]) |
                   ({DATA_W{ s1 & ~s0}} & din[2*DATA_W +: DATA_W]) |
                   ({DATA_W{ s1 &  s0}} & din[3*DATA_W +: DATA_W])) & {DATA_W{valid}};

endmodule
